stopwatch_ctrl: RTL and testbench

Control sequencer for the 50 MHz stopwatch. It turns the two raw push-buttons into debounced press events and runs a four-state run/stop/lap/clear machine. It drives the clear, run and count-enable signals of the 10 ms timer and the six-digit BCD counter chain, plus a hold signal for the display latch. It sits between KEY[1:0] and the timer/counter/encoder datapath, and replaces the two ad-hoc toggle instances.

---
 rtl/stopwatch_pkg.sv | 63 ++++++
 rtl/stopwatch_ctrl_debounce.sv | 78 +++++++
 rtl/stopwatch_ctrl.sv | 75 +++++++
 tb/tb_stopwatch_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path and its datapath.
package stopwatch_pkg;

  // Run/stop/lap/clear state encodings (visible on state_o)
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } sw_state_t;

  // Level outputs decoded from a state
  typedef struct packed {
    logic clr;
    logic timer_run;
    logic disp_hold;
    logic led_run;
    logic led_lap;
  } sw_out_t;

  // 20 ms of stable level at 50 MHz
  localparam int unsigned DB_CYCLES_DEFAULT = 1_000_000;
  localparam int unsigned DB_W_DEFAULT      = 20;

  // BCD digit limits used by the counter chain (units digits / tens digits)
  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  // Level outputs for a given state
  function automatic sw_out_t decode_state(input sw_state_t s);
    sw_out_t o;
    o.clr       = (s == ST_IDLE);
    o.timer_run = (s == ST_RUN) || (s == ST_LAP);
    o.disp_hold = (s == ST_LAP);
    o.led_run   = (s == ST_RUN) || (s == ST_LAP);
    o.led_lap   = (s == ST_LAP);
    return o;
  endfunction

  // Transition table; a start/stop press takes priority over a lap/reset press
  function automatic sw_state_t next_state(input sw_state_t s, input logic ss, input logic lr);
    sw_state_t n;
    n = s;
    unique case (s)
      ST_IDLE: if (ss) n = ST_RUN;
      ST_RUN: begin
        if (ss)      n = ST_STOP;
        else if (lr) n = ST_LAP;
      end
      ST_LAP: begin
        if (ss)      n = ST_STOP;
        else if (lr) n = ST_RUN;
      end
      ST_STOP: begin
        if (ss)      n = ST_RUN;
        else if (lr) n = ST_IDLE;
      end
      default: n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debouncer and
// one-cycle press pulse on the debounced falling edge (buttons are active-low).
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned DB_W      = DB_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [1:0]      sync_vld;
  logic            stb;
  logic [DB_W-1:0] cnt;
  logic [DB_W-1:0] rel_cnt;
  logic            armed;

  // Bring the raw key into the clock domain; sync_vld marks when sync2 holds a real sample
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      sync_vld <= '0;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // Track the stable level and emit a pulse when it falls to pressed
  always_ff @(posedge clk) begin
    if (reset) begin
      stb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == stb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stb   <= sync2;
        cnt   <= '0;
        press <= armed & ~sync2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

  // Presses are accepted only after the key has been seen released for a full
  // debounce window since reset, so a key held through reset is not replayed.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed   <= 1'b0;
      rel_cnt <= '0;
    end else if (!armed) begin
      if (sync_vld[1] && sync2) begin
        if (rel_cnt == CNT_LAST) begin
          armed   <= 1'b1;
          rel_cnt <= '0;
        end else begin
          rel_cnt <= rel_cnt + DB_W'(1);
        end
      end else begin
        rel_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced start/stop and lap/reset keys drive a
// four-state run/stop/lap/clear machine controlling the timer, counters and display latch.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned DB_W      = DB_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_ss_n,
  input  logic       key_lr_n,
  input  logic       tick,
  output logic       clr,
  output logic       timer_run,
  output logic       count_en,
  output logic       disp_hold,
  output logic [1:0] state_o,
  output logic       led_run,
  output logic       led_lap
);

  logic      ss_press;
  logic      lr_press;
  sw_state_t state_q;
  sw_state_t state_nxt;
  sw_out_t   outs_q;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_db_ss (
    .clk   (clk),
    .reset (reset),
    .key_n (key_ss_n),
    .press (ss_press)
  );

  key_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_db_lr (
    .clk   (clk),
    .reset (reset),
    .key_n (key_lr_n),
    .press (lr_press)
  );

  // Next state from the press events
  always_comb begin
    state_nxt = next_state(state_q, ss_press, lr_press);
  end

  // State register; level outputs are registered from the next state so they change with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      outs_q  <= decode_state(ST_IDLE);
    end else begin
      state_q <= state_nxt;
      outs_q  <= decode_state(state_nxt);
    end
  end

  assign state_o   = state_q;
  assign clr       = outs_q.clr;
  assign timer_run = outs_q.timer_run;
  assign disp_hold = outs_q.disp_hold;
  assign led_run   = outs_q.led_run;
  assign led_lap   = outs_q.led_lap;

  // tick is judged against the current state, so a tick in the leaving cycle still counts
  assign count_en  = tick & outs_q.timer_run;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle debounce window.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_ss_n;
  logic       key_lr_n;
  logic       tick;
  logic       clr;
  logic       timer_run;
  logic       count_en;
  logic       disp_hold;
  logic [1:0] state_o;
  logic       led_run;
  logic       led_lap;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_LAP  = 2'b10;
  localparam logic [1:0] S_STOP = 2'b11;

  typedef struct {
    logic        ss_n;
    logic        lr_n;
    logic        tk;
    int unsigned reps;
    logic [1:0]  st;
    logic        cen;
    string       name;
  } vec_t;

  vec_t vecs[$];

  stopwatch_ctrl #(
    .DB_CYCLES (4),
    .DB_W      (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_ss_n  (key_ss_n),
    .key_lr_n  (key_lr_n),
    .tick      (tick),
    .clr       (clr),
    .timer_run (timer_run),
    .count_en  (count_en),
    .disp_hold (disp_hold),
    .state_o   (state_o),
    .led_run   (led_run),
    .led_lap   (led_lap)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic ss, input logic lr, input logic tk,
                              input int unsigned n, input logic [1:0] st,
                              input logic cen, input string name);
    vec_t v;
    v.ss_n = ss; v.lr_n = lr; v.tk = tk; v.reps = n;
    v.st = st; v.cen = cen; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check_cycle(input string name, input logic [1:0] st, input logic cen);
    logic [6:0] exp_v;
    logic [6:0] act_v;
    exp_v = {st, st == S_IDLE, (st == S_RUN) || (st == S_LAP), cen,
             st == S_LAP, (st == S_RUN) || (st == S_LAP), st == S_LAP};
    act_v = {state_o, clr, timer_run, count_en, disp_hold, led_run, led_lap};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s @%0t: {state,clr,run,cen,hold,led_run,led_lap} got=%b required=%b",
               name, $time, act_v, exp_v);
    end
  endtask

  // Drive inputs just after a rising edge, check at the falling edge, repeat n cycles
  task automatic apply(input logic ss, input logic lr, input logic tk, input int unsigned n,
                       input logic [1:0] st, input logic cen, input string name);
    for (int unsigned i = 0; i < n; i++) begin
      key_ss_n = ss;
      key_lr_n = lr;
      tick     = tk;
      @(negedge clk);
      check_cycle(name, st, cen);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    key_ss_n = 1'b1;
    key_lr_n = 1'b1;
    tick     = 1'b0;

    // Key low first sampled at edge k+1; pulse after edge k+6; new state from edge k+7
    add(1, 1, 0, 20, S_IDLE, 0, "idle");
    add(1, 1, 1,  2, S_IDLE, 0, "idle_tick");
    add(0, 1, 0,  6, S_IDLE, 0, "ss_debouncing");
    add(0, 1, 1,  1, S_IDLE, 0, "tick_entering_run");
    add(0, 1, 0,  9, S_RUN,  0, "ss_held_once");
    add(1, 1, 0,  8, S_RUN,  0, "ss_release");
    add(1, 1, 1,  1, S_RUN,  1, "run_tick");
    add(1, 1, 0,  1, S_RUN,  0, "run_no_tick");
    add(0, 1, 0,  3, S_RUN,  0, "glitch3");
    add(1, 1, 0,  8, S_RUN,  0, "after_glitch");
    add(1, 0, 0,  7, S_RUN,  0, "lr_debouncing");
    add(1, 0, 0,  1, S_LAP,  0, "enter_lap");
    add(1, 1, 1,  1, S_LAP,  1, "lap_tick");
    add(1, 1, 0,  8, S_LAP,  0, "lap_hold");
    add(1, 0, 0,  7, S_LAP,  0, "lr_again");
    add(1, 1, 0,  8, S_RUN,  0, "lap_to_run");
    add(0, 0, 0,  7, S_RUN,  0, "both_keys");
    add(1, 1, 0,  8, S_STOP, 0, "both_ss_wins");
    add(1, 0, 1,  7, S_STOP, 0, "stop_tick_lr");
    add(1, 1, 0,  8, S_IDLE, 0, "stop_to_idle");
    add(1, 0, 0,  7, S_IDLE, 0, "idle_lr");
    add(1, 1, 0,  8, S_IDLE, 0, "idle_lr_noop");
    add(0, 1, 0,  7, S_IDLE, 0, "restart");
    add(1, 1, 0,  8, S_RUN,  0, "restart_run");
    add(0, 1, 0,  6, S_RUN,  0, "ss_in_run");
    add(0, 1, 1,  1, S_RUN,  1, "tick_leaving_run");
    add(1, 1, 1,  1, S_STOP, 0, "tick_after_stop");
    add(1, 1, 0,  8, S_STOP, 0, "stopped");
    add(0, 1, 0,  7, S_STOP, 0, "resume");
    add(1, 1, 0,  8, S_RUN,  0, "resumed_run");
    add(1, 0, 0,  7, S_RUN,  0, "lap2");
    add(1, 1, 0,  8, S_LAP,  0, "lap2_hold");
    add(0, 1, 0,  6, S_LAP,  0, "ss_in_lap");
    add(0, 1, 1,  1, S_LAP,  1, "tick_leaving_lap");
    add(1, 1, 1,  1, S_STOP, 0, "lap_to_stop");
    add(1, 1, 0,  7, S_STOP, 0, "stopped2");

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_cycle("reset_state", S_IDLE, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].ss_n, vecs[i].lr_n, vecs[i].tk, vecs[i].reps,
            vecs[i].st, vecs[i].cen, vecs[i].name);
    end

    // Reset while start/stop is held mid-debounce: no event until release and re-press
    apply(0, 1, 0, 4, S_STOP, 0, "held_pre_reset");
    reset = 1'b1;
    apply(0, 1, 0, 1, S_STOP, 0, "reset_drive_cycle");
    reset = 1'b0;
    apply(0, 1, 0, 15, S_IDLE, 0, "held_after_reset");
    apply(1, 1, 0,  8, S_IDLE, 0, "release_after_reset");
    apply(0, 1, 0,  7, S_IDLE, 0, "repress");
    apply(1, 1, 0,  8, S_RUN,  0, "repress_run");
    apply(1, 1, 1,  1, S_RUN,  1, "repress_tick");

    // Reset in the middle of a run
    reset = 1'b1;
    apply(1, 1, 1, 1, S_RUN,  1, "mid_run_reset_cycle");
    reset = 1'b0;
    apply(1, 1, 1, 3, S_IDLE, 0, "after_mid_run_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
